// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyphs, off codes, digit indices.
package seg_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned DIG_N   = 4;
  localparam int unsigned SCAN_W  = 2;

  // Active-high g..a segment patterns
  localparam logic [GLYPH_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [GLYPH_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [GLYPH_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [GLYPH_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [GLYPH_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [GLYPH_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [GLYPH_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [GLYPH_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [GLYPH_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [GLYPH_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [GLYPH_W-1:0] GLYPH_A = 7'h77;
  localparam logic [GLYPH_W-1:0] GLYPH_B = 7'h7C;
  localparam logic [GLYPH_W-1:0] GLYPH_C = 7'h39;
  localparam logic [GLYPH_W-1:0] GLYPH_D = 7'h5E;
  localparam logic [GLYPH_W-1:0] GLYPH_E = 7'h79;
  localparam logic [GLYPH_W-1:0] GLYPH_F = 7'h71;

  localparam logic [SEG_W-1:0] SEG_OFF   = 8'hFF;
  localparam logic [DIG_N-1:0] DIGIT_OFF = 4'hF;

  localparam logic [SCAN_W-1:0] DIG_UNITS     = 2'd0;
  localparam logic [SCAN_W-1:0] DIG_TENS      = 2'd1;
  localparam logic [SCAN_W-1:0] DIG_HUNDREDS  = 2'd2;
  localparam logic [SCAN_W-1:0] DIG_THOUSANDS = 2'd3;

  // Per-frame input snapshot; val[3] is the leftmost digit
  typedef struct packed {
    logic [DIG_N-1:0][NIB_W-1:0] val;
    logic [DIG_N-1:0]            dp;
    logic                        blank_lz;
  } snap_t;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational nibble-to-glyph decoder; hex digits A..F are always shown.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0]   i_val,
  output logic [GLYPH_W-1:0] o_glyph_c
);

  // Decode one nibble to its active-high segment pattern
  always_comb begin
    o_glyph_c = GLYPH_0;
    case (i_val)
      4'h0: o_glyph_c = GLYPH_0;
      4'h1: o_glyph_c = GLYPH_1;
      4'h2: o_glyph_c = GLYPH_2;
      4'h3: o_glyph_c = GLYPH_3;
      4'h4: o_glyph_c = GLYPH_4;
      4'h5: o_glyph_c = GLYPH_5;
      4'h6: o_glyph_c = GLYPH_6;
      4'h7: o_glyph_c = GLYPH_7;
      4'h8: o_glyph_c = GLYPH_8;
      4'h9: o_glyph_c = GLYPH_9;
      4'hA: o_glyph_c = GLYPH_A;
      4'hB: o_glyph_c = GLYPH_B;
      4'hC: o_glyph_c = GLYPH_C;
      4'hD: o_glyph_c = GLYPH_D;
      4'hE: o_glyph_c = GLYPH_E;
      4'hF: o_glyph_c = GLYPH_F;
      default: o_glyph_c = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode scan driver: per-frame snapshot, leading-zero blanking,
// anti-ghosting blank interval at the start of every digit slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 12500,
  parameter int unsigned BLANK_TICKS = 64
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [NIB_W-1:0] units,
  input  logic [NIB_W-1:0] tens,
  input  logic [NIB_W-1:0] hundreds,
  input  logic [NIB_W-1:0] thousands,
  input  logic [DIG_N-1:0] dp_en,
  input  logic             blank_lz,
  output logic [SEG_W-1:0] SEG,
  output logic [DIG_N-1:0] DIGIT,
  output logic             frame_tick
);

  localparam int unsigned TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_TICKS);

  logic [TICK_W-1:0]  r_tick;
  logic [SCAN_W-1:0]  r_scan_idx;
  snap_t              r_snap;

  logic               w_slot_end;
  logic               w_capture;
  logic [NIB_W-1:0]   w_cur_val;
  logic [GLYPH_W-1:0] w_glyph;
  logic               w_lz_zero;
  logic               w_blank;
  logic [SEG_W-1:0]   w_seg_nxt;
  logic [DIG_N-1:0]   w_digit_nxt;

  assign w_slot_end = (r_tick == TICK_LAST);
  assign w_capture  = w_slot_end && (r_scan_idx == DIG_THOUSANDS);

  // Slot tick counter and digit scan index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tick     <= '0;
      r_scan_idx <= DIG_UNITS;
    end else if (w_slot_end) begin
      r_tick     <= '0;
      r_scan_idx <= r_scan_idx + SCAN_W'(1);
    end else begin
      r_tick     <= r_tick + TICK_W'(1);
    end
  end

  // Latch all inputs once per frame, on the same edge that starts the units slot
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_snap <= '0;
    end else if (w_capture) begin
      r_snap <= {thousands, hundreds, tens, units, dp_en, blank_lz};
    end
  end

  assign w_cur_val = r_snap.val[r_scan_idx];

  seg_glyph_rom u_glyph_rom (
    .i_val     (w_cur_val),
    .o_glyph_c (w_glyph)
  );

  // True when this digit and every digit to its left hold zero (units excluded)
  always_comb begin
    w_lz_zero = 1'b0;
    case (r_scan_idx)
      DIG_THOUSANDS: w_lz_zero = (r_snap.val[3] == 4'd0);
      DIG_HUNDREDS:  w_lz_zero = ((r_snap.val[3] | r_snap.val[2]) == 4'd0);
      DIG_TENS:      w_lz_zero = ((r_snap.val[3] | r_snap.val[2] | r_snap.val[1]) == 4'd0);
      default:       w_lz_zero = 1'b0;
    endcase
  end

  // Blank during the slot guard time, or for a suppressed leading zero without dp
  always_comb begin
    w_blank     = (r_tick < TICK_BLANK) ||
                  (w_lz_zero && r_snap.blank_lz && !r_snap.dp[r_scan_idx]);
    w_seg_nxt   = SEG_OFF;
    w_digit_nxt = DIGIT_OFF;
    if (!w_blank) begin
      w_seg_nxt   = {~r_snap.dp[r_scan_idx], ~w_glyph};
      w_digit_nxt = DIG_N'(~(4'b0001 << r_scan_idx));
    end
  end

  // Registered active-low drives and frame pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEG        <= SEG_OFF;
      DIGIT      <= DIGIT_OFF;
      frame_tick <= 1'b0;
    end else begin
      SEG        <= w_seg_nxt;
      DIGIT      <= w_digit_nxt;
      frame_tick <= w_capture;
    end
  end

endmodule
